// File: rtl/axi_sram_slave.sv
// AXI slave endpoint bridging one-at-a-time AR/R and AW/W/B bursts (INCR/FIXED,
// 32-bit beats) onto a single-port synchronous SRAM with per-byte write enables.
module axi_sram_slave #(
    parameter int ID_W    = 8,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 4,
    parameter int SRAM_AW = 14
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    input  logic [ID_W-1:0]    arid,
    input  logic [ADDR_W-1:0]  araddr,
    input  logic [LEN_W-1:0]   arlen,
    input  logic [2:0]         arsize,
    input  logic [1:0]         arburst,
    input  logic               arvalid,
    output logic               arready,
    output logic [ID_W-1:0]    rid,
    output logic [31:0]        rdata,
    output logic [1:0]         rresp,
    output logic               rlast,
    output logic               rvalid,
    input  logic               rready,
    input  logic [ID_W-1:0]    awid,
    input  logic [ADDR_W-1:0]  awaddr,
    input  logic [LEN_W-1:0]   awlen,
    input  logic [2:0]         awsize,
    input  logic [1:0]         awburst,
    input  logic               awvalid,
    output logic               awready,
    input  logic [31:0]        wdata,
    input  logic [3:0]         wstrb,
    input  logic               wlast,
    input  logic               wvalid,
    output logic               wready,
    output logic [ID_W-1:0]    bid,
    output logic [1:0]         bresp,
    output logic               bvalid,
    input  logic               bready,
    output logic               sram_ceb,
    output logic [3:0]         sram_web,
    output logic [SRAM_AW-1:0] sram_a,
    output logic [31:0]        sram_di,
    input  logic [31:0]        sram_do
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        R_ACC  = 3'd1,
        R_DATA = 3'd2,
        W_DATA = 3'd3,
        B_RESP = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ID_W-1:0]   id_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_next_s;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  beat_r;
    logic              fixed_r;
    logic              first_r;
    logic [31:0]       rdata_hold_r;
    logic              last_beat_s;
    logic              unused_s;

    // Size fields, awlen and the byte/high address bits play no part in the datapath.
    assign unused_s    = ^{arsize, awsize, awlen, addr_r};
    assign addr_next_s = fixed_r ? addr_r : (addr_r + ADDR_W'(4));
    assign last_beat_s = (beat_r == len_r);
    assign rresp       = 2'b00;
    assign bresp       = 2'b00;

    // Next-state selection; a pending write takes priority over a read in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (awvalid) begin
                    state_s = W_DATA;
                end else if (arvalid) begin
                    state_s = R_ACC;
                end else begin
                    state_s = IDLE;
                end
            end
            R_ACC:  state_s = R_DATA;
            R_DATA: begin
                if (rready) begin
                    state_s = last_beat_s ? IDLE : R_ACC;
                end else begin
                    state_s = R_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wlast) begin
                    state_s = B_RESP;
                end else begin
                    state_s = W_DATA;
                end
            end
            B_RESP: begin
                if (bready) begin
                    state_s = IDLE;
                end else begin
                    state_s = B_RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Handshake and SRAM outputs; everything is forced idle while ARESETn is low.
    always_comb begin
        arready  = 1'b0;
        awready  = 1'b0;
        wready   = 1'b0;
        rvalid   = 1'b0;
        rlast    = 1'b0;
        rid      = '0;
        rdata    = 32'h0000_0000;
        bvalid   = 1'b0;
        bid      = '0;
        sram_ceb = 1'b1;
        sram_web = 4'hF;
        sram_a   = addr_r[SRAM_AW+1:2];
        sram_di  = wdata;
        if (ARESETn) begin
            case (state_r)
                IDLE: begin
                    awready = 1'b1;
                    arready = ~awvalid;
                end
                R_ACC: sram_ceb = 1'b0;
                R_DATA: begin
                    rvalid = 1'b1;
                    rid    = id_r;
                    rlast  = last_beat_s;
                    rdata  = first_r ? sram_do : rdata_hold_r;
                end
                W_DATA: begin
                    wready = 1'b1;
                    if (wvalid) begin
                        sram_ceb = 1'b0;
                        sram_web = ~wstrb;
                    end else begin
                        sram_ceb = 1'b1;
                    end
                end
                B_RESP: begin
                    bvalid = 1'b1;
                    bid    = id_r;
                end
                default: sram_ceb = 1'b1;
            endcase
        end else begin
            sram_ceb = 1'b1;
        end
    end

    // State register plus burst context (ID, address, length, beat, read capture).
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_r      <= IDLE;
            id_r         <= '0;
            addr_r       <= '0;
            len_r        <= '0;
            beat_r       <= '0;
            fixed_r      <= 1'b0;
            first_r      <= 1'b0;
            rdata_hold_r <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (awvalid) begin
                        id_r    <= awid;
                        addr_r  <= awaddr;
                        fixed_r <= (awburst == 2'b00);
                    end else if (arvalid) begin
                        id_r    <= arid;
                        addr_r  <= araddr;
                        len_r   <= arlen;
                        fixed_r <= (arburst == 2'b00);
                        beat_r  <= '0;
                    end else begin
                        beat_r  <= beat_r;
                    end
                end
                R_ACC: first_r <= 1'b1;
                R_DATA: begin
                    first_r <= 1'b0;
                    if (first_r) begin
                        rdata_hold_r <= sram_do;
                    end else begin
                        rdata_hold_r <= rdata_hold_r;
                    end
                    if (rready && !last_beat_s) begin
                        beat_r <= beat_r + LEN_W'(1);
                        addr_r <= addr_next_s;
                    end else begin
                        beat_r <= beat_r;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        addr_r <= addr_next_s;
                    end else begin
                        addr_r <= addr_r;
                    end
                end
                default: first_r <= 1'b0;
            endcase
        end
    end

endmodule
